dual_port_mem_arb: RTL and testbench
====================================

// Module: dual_port_mem_arb
// PURPOSE
//  Parametrised true dual-port synchronous RAM; next generation of the 16-bit two-port memory.
//  Adds deterministic write-collision arbitration, read-during-write forwarding, read-valid
//  strobes and a hardware clear sequencer.
//  Sits between the datapath (port 1) and the load/store / DMA side (port 2) in the processor.
// PARAMETERS
//  DATA_WIDTH  16  word width in bits
//  ADDR_WIDTH  10  address bits; DEPTH = 2**ADDR_WIDTH words
// PORTS
//  CLK         in   1           clock; all state updates on rising edge
//  Reset       in   1           synchronous, active-high reset
//  Clear       in   1           1-cycle request: zero entire array
//  Busy        out  1           high while clear sequence runs
//  DataIn_1    in   DATA_WIDTH  port-1 write data
//  Address_1   in   ADDR_WIDTH  port-1 address
//  WriteEna_1  in   1           port-1 write enable
//  ReadEna_1   in   1           port-1 read enable
//  DataOut_1   out  DATA_WIDTH  port-1 read data
//  ReadValid_1 out  1           DataOut_1 updated this cycle
//  DataIn_2 / Address_2 / WriteEna_2 / ReadEna_2 / DataOut_2 / ReadValid_2: same for port 2
//  Collision   out  1           1-cycle pulse: both ports wrote same address
// BEHAVIOUR
//  - Reset (sync, active-high, priority over all): DataOut_1/2=0, ReadValid_1/2=0, Collision=0,
//    Busy=0, FSM->IDLE, clear counter=0. Array contents NOT reset.
//  - FSM states: IDLE, CLEAR. IDLE->CLEAR when Clear=1 (edge it is sampled on). CLEAR writes 0
//    to addr cnt each cycle, cnt 0..DEPTH-1; after writing DEPTH-1 -> IDLE, cnt=0.
//    Busy=1 exactly DEPTH cycles (registered, from the edge after Clear).
//  - During CLEAR all port enables ignored: no writes, no reads, ReadValid=0, DataOut holds.
//    Clear while Busy ignored. Reset mid-clear aborts: IDLE, Busy=0; words not yet cleared keep
//    old values.
//  - Write (IDLE): WriteEna_n=1 -> mem[Address_n]<=DataIn_n at edge.
//    Both write same address -> port 1 data stored, port 2 dropped, Collision=1 next cycle.
//    Different addresses -> both stored. Collision=0 otherwise.
//  - Read (IDLE): ReadEna_n=1 -> DataOut_n = word at Address_n, ReadValid_n=1, one cycle after
//    the request edge (latency 1). ReadEna_n=0 -> DataOut_n holds, ReadValid_n=0.
//  - Read-during-write forwarding (write-first): if the read address equals an address written
//    in the same cycle (either port), DataOut returns the new data. If both ports write that
//    address, port 1 data is returned (matches the stored value).
//  - Read+write on the same port, same cycle: both performed; DataOut = DataIn (forwarding).
//  - Addresses are full ADDR_WIDTH; no wrap or out-of-range case exists.
// CONFIGURATION
//  MEM_OUT_REG_EN defined: extra output register stage on DataOut_n and ReadValid_n;
//    read latency 2; forwarding still applied at stage 1; reset clears both stages;
//    stage-2 holds value when stage 1 not valid.
//  Undefined: latency 1 as above. Collision and Busy timing identical in both builds.
// TESTING (ADDR_WIDTH=4, DATA_WIDTH=16)
//  1 Reset=1 2 cycles -> all outputs 0, Busy=0; then write 16'hBEEF @3 via port 1, read @3 via
//    port 2 next cycle -> DataOut_2=BEEF, ReadValid_2=1 one cycle later.
//  2 Same cycle: P1 writes 1111 @5, P2 writes 2222 @5 -> Collision pulse 1 cycle; later read
//    @5 = 1111.
//  3 P1 writes ABCD @7 while P2 reads @7 same cycle -> DataOut_2=ABCD next cycle (forwarded).
//  4 Fill @0..15 nonzero, pulse Clear -> Busy high 16 cycles, reads ignored (ReadValid=0);
//    afterwards all 16 words read 0.
//  5 Clear, Reset at Busy cycle 5 -> Busy=0 next cycle; @0..4 read 0, @5..15 retain old data.
//  6 MEM_OUT_REG_EN build: repeat 1 and 3 -> same data, ReadValid 2 cycles after request.

Source files
------------

// File: rtl/dual_port_mem_arb_if.sv
// dual_port_mem_arb_if: port-1/port-2 bus, clear request and status signals of the dual-port RAM
interface dual_port_mem_arb_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  Clear;
  logic                  Busy;
  logic                  Collision;
  logic [DATA_WIDTH-1:0] DataIn_1;
  logic [ADDR_WIDTH-1:0] Address_1;
  logic                  WriteEna_1;
  logic                  ReadEna_1;
  logic [DATA_WIDTH-1:0] DataOut_1;
  logic                  ReadValid_1;
  logic [DATA_WIDTH-1:0] DataIn_2;
  logic [ADDR_WIDTH-1:0] Address_2;
  logic                  WriteEna_2;
  logic                  ReadEna_2;
  logic [DATA_WIDTH-1:0] DataOut_2;
  logic                  ReadValid_2;
  modport master (
    output Clear, DataIn_1, Address_1, WriteEna_1, ReadEna_1,
           DataIn_2, Address_2, WriteEna_2, ReadEna_2,
    input  Busy, Collision, DataOut_1, ReadValid_1, DataOut_2, ReadValid_2
  );
  modport slave (
    input  Clear, DataIn_1, Address_1, WriteEna_1, ReadEna_1,
           DataIn_2, Address_2, WriteEna_2, ReadEna_2,
    output Busy, Collision, DataOut_1, ReadValid_1, DataOut_2, ReadValid_2
  );
endinterface

// File: rtl/dual_port_mem_arb.sv
// dual_port_mem_arb: true dual-port RAM with port-1-wins write arbitration, write-first forwarding and clear sequencer
// MEM_OUT_REG_EN adds a second output register stage (read latency 2).
module dual_port_mem_arb #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input logic              CLK,
  input logic              Reset,
  dual_port_mem_arb_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] dout1_q, dout1_d, dout2_q, dout2_d, fwd1, fwd2;
  logic                  rv1_q, rv1_d, rv2_q, rv2_d, coll_q, coll_d;
  logic                  idle, same;
  always_comb begin
    idle    = state_q == IDLE;
    same    = bus.Address_1 == bus.Address_2;
    fwd1    = bus.WriteEna_1 ? bus.DataIn_1 : (bus.WriteEna_2 && same) ? bus.DataIn_2 : mem[bus.Address_1];
    fwd2    = (bus.WriteEna_1 && same) ? bus.DataIn_1 : bus.WriteEna_2 ? bus.DataIn_2 : mem[bus.Address_2];
    state_d = idle ? (bus.Clear ? CLEAR : IDLE) : (&cnt_q ? IDLE : CLEAR);
    cnt_d   = idle ? '0 : cnt_q + 1'b1;
    rv1_d   = idle && bus.ReadEna_1;
    rv2_d   = idle && bus.ReadEna_2;
    dout1_d = rv1_d ? fwd1 : dout1_q;
    dout2_d = rv2_d ? fwd2 : dout2_q;
    coll_d  = idle && bus.WriteEna_1 && bus.WriteEna_2 && same;
  end
  // array is never reset; a reset edge suppresses the write of that cycle
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      if (!idle) mem[cnt_q] <= '0;
      else begin
        if (bus.WriteEna_1) mem[bus.Address_1] <= bus.DataIn_1;
        if (bus.WriteEna_2 && !(bus.WriteEna_1 && same)) mem[bus.Address_2] <= bus.DataIn_2;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout1_q <= '0;
      dout2_q <= '0;
      rv1_q   <= 1'b0;
      rv2_q   <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout1_q <= dout1_d;
      dout2_q <= dout2_d;
      rv1_q   <= rv1_d;
      rv2_q   <= rv2_d;
      coll_q  <= coll_d;
    end
  end
  assign bus.Busy      = state_q == CLEAR;
  assign bus.Collision = coll_q;
`ifdef MEM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] dout1_s_q, dout1_s_d, dout2_s_q, dout2_s_d;
  logic                  rv1_s_q, rv1_s_d, rv2_s_q, rv2_s_d;
  always_comb begin
    dout1_s_d = rv1_q ? dout1_q : dout1_s_q;
    dout2_s_d = rv2_q ? dout2_q : dout2_s_q;
    rv1_s_d   = rv1_q;
    rv2_s_d   = rv2_q;
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      dout1_s_q <= '0;
      dout2_s_q <= '0;
      rv1_s_q   <= 1'b0;
      rv2_s_q   <= 1'b0;
    end else begin
      dout1_s_q <= dout1_s_d;
      dout2_s_q <= dout2_s_d;
      rv1_s_q   <= rv1_s_d;
      rv2_s_q   <= rv2_s_d;
    end
  end
  assign bus.DataOut_1   = dout1_s_q;
  assign bus.DataOut_2   = dout2_s_q;
  assign bus.ReadValid_1 = rv1_s_q;
  assign bus.ReadValid_2 = rv2_s_q;
`else
  assign bus.DataOut_1   = dout1_q;
  assign bus.DataOut_2   = dout2_q;
  assign bus.ReadValid_1 = rv1_q;
  assign bus.ReadValid_2 = rv2_q;
`endif
endmodule

// File: tb/tb_dual_port_mem_arb.sv
// tb_dual_port_mem_arb: directed scenarios plus random traffic checked every cycle against a memory-array reference model
module tb_dual_port_mem_arb;
`ifdef MEM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  dual_port_mem_arb_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus ();
  dual_port_mem_arb #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (.CLK(clk), .Reset(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [15:0] m_mem [16];
  int          busy_left = 0;
  int          clr_idx = 0;
  logic [15:0] s1d [2];
  logic [15:0] od [2];
  logic        s1v [2];
  logic        ov [2];
  logic        ocoll = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // reference: apply port 2 then port 1 writes to a copy, reads see the copy (write-first, port 1 wins)
  task automatic model_step();
    logic [15:0] nm [16];
    logic [15:0] rd [2];
    logic        rv [2];
    rd[0] = '0; rd[1] = '0; rv[0] = 1'b0; rv[1] = 1'b0;
    if (rst) begin
      busy_left = 0; clr_idx = 0; ocoll = 1'b0;
      for (int p = 0; p < 2; p++) begin s1d[p] = '0; s1v[p] = 1'b0; od[p] = '0; ov[p] = 1'b0; end
      return;
    end
    if (busy_left > 0) begin
      m_mem[clr_idx] = '0;
      clr_idx++;
      busy_left--;
      ocoll = 1'b0;
    end else begin
      nm = m_mem;
      if (bus.WriteEna_2) nm[bus.Address_2] = bus.DataIn_2;
      if (bus.WriteEna_1) nm[bus.Address_1] = bus.DataIn_1;
      rv[0] = bus.ReadEna_1; rd[0] = nm[bus.Address_1];
      rv[1] = bus.ReadEna_2; rd[1] = nm[bus.Address_2];
      ocoll = bus.WriteEna_1 && bus.WriteEna_2 && bus.Address_1 == bus.Address_2;
      m_mem = nm;
      if (bus.Clear) begin busy_left = 16; clr_idx = 0; end
    end
    for (int p = 0; p < 2; p++) begin
      if (LAT == 2) begin
        if (s1v[p]) od[p] = s1d[p];
        ov[p] = s1v[p];
      end
      if (rv[p]) s1d[p] = rd[p];
      s1v[p] = rv[p];
      if (LAT == 1) begin od[p] = s1d[p]; ov[p] = s1v[p]; end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("busy", 32'(bus.Busy), 32'(busy_left > 0));
    chk("collision", 32'(bus.Collision), 32'(ocoll));
    chk("rv1", 32'(bus.ReadValid_1), 32'(ov[0]));
    chk("rv2", 32'(bus.ReadValid_2), 32'(ov[1]));
    chk("dout1", 32'(bus.DataOut_1), 32'(od[0]));
    chk("dout2", 32'(bus.DataOut_2), 32'(od[1]));
  endtask
  task automatic quiet();
    rst = 1'b0; bus.Clear = 1'b0;
    bus.WriteEna_1 = 1'b0; bus.ReadEna_1 = 1'b0; bus.WriteEna_2 = 1'b0; bus.ReadEna_2 = 1'b0;
  endtask
  task automatic wr1(input logic [3:0] a, input logic [15:0] d);
    quiet(); bus.WriteEna_1 = 1'b1; bus.Address_1 = a; bus.DataIn_1 = d; tick();
  endtask
  // issue a read, then idle until the data has landed at the output
  task automatic rd_chk(input string tag, input int port, input logic [3:0] a, input logic [15:0] exp);
    quiet();
    if (port == 1) begin bus.ReadEna_1 = 1'b1; bus.Address_1 = a; end
    else begin bus.ReadEna_2 = 1'b1; bus.Address_2 = a; end
    tick(); quiet(); tick(); tick();
    chk(tag, 32'(port == 1 ? bus.DataOut_1 : bus.DataOut_2), 32'(exp));
  endtask
  initial begin
    int n;
    quiet(); rst = 1'b1;
    bus.Address_1 = '0; bus.Address_2 = '0; bus.DataIn_1 = '0; bus.DataIn_2 = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = 'x;
    tick(); tick();
    chk("rst_busy", 32'(bus.Busy), 0);
    chk("rst_dout1", 32'(bus.DataOut_1), 0);
    chk("rst_dout2", 32'(bus.DataOut_2), 0);
    chk("rst_rv", 32'({bus.ReadValid_1, bus.ReadValid_2, bus.Collision}), 0);
    // scenario 1: write then read on the other port, check latency
    wr1(4'd3, 16'hBEEF);
    quiet(); bus.ReadEna_2 = 1'b1; bus.Address_2 = 4'd3;
    for (int k = 1; k <= LAT; k++) begin
      tick(); quiet();
      chk("t1_rv2", 32'(bus.ReadValid_2), 32'(k == LAT));
    end
    chk("t1_dout2", 32'(bus.DataOut_2), 32'h0000BEEF);
    // scenario 2: write collision
    quiet(); bus.WriteEna_1 = 1'b1; bus.WriteEna_2 = 1'b1;
    bus.Address_1 = 4'd5; bus.Address_2 = 4'd5; bus.DataIn_1 = 16'h1111; bus.DataIn_2 = 16'h2222;
    tick();
    chk("t2_coll", 32'(bus.Collision), 1);
    quiet(); tick();
    chk("t2_coll_end", 32'(bus.Collision), 0);
    rd_chk("t2_rd5", 2, 4'd5, 16'h1111);
    // scenario 3: forwarding across ports and on the same port
    quiet(); bus.WriteEna_1 = 1'b1; bus.Address_1 = 4'd7; bus.DataIn_1 = 16'hABCD;
    bus.ReadEna_2 = 1'b1; bus.Address_2 = 4'd7;
    tick(); quiet(); tick(); tick();
    chk("t3_fwd", 32'(bus.DataOut_2), 32'h0000ABCD);
    quiet(); bus.WriteEna_2 = 1'b1; bus.ReadEna_2 = 1'b1; bus.Address_2 = 4'd9; bus.DataIn_2 = 16'h5A5A;
    tick(); quiet(); tick(); tick();
    chk("t3_same_port", 32'(bus.DataOut_2), 32'h00005A5A);
    // scenario 4: fill then clear with reads attempted throughout
    for (int i = 0; i < 16; i++) wr1(4'(i), 16'hC000 + 16'(i));
    quiet(); bus.Clear = 1'b1; tick();
    n = 0;
    while (bus.Busy && n < 40) begin
      quiet(); bus.ReadEna_1 = 1'b1; bus.ReadEna_2 = 1'b1; bus.Address_1 = 4'(n); bus.Address_2 = 4'(n + 3);
      bus.Clear = (n == 4); n++; tick();
    end
    chk("t4_busy_len", 32'(n), 16);
    for (int i = 0; i < 16; i++) rd_chk("t4_zero", 1 + (i & 1), 4'(i), 16'h0000);
    // scenario 5: reset aborts clear after five words
    for (int i = 0; i < 16; i++) wr1(4'(i), 16'hA000 + 16'(i));
    quiet(); bus.Clear = 1'b1; tick();
    quiet(); for (int i = 0; i < 5; i++) tick();
    rst = 1'b1; tick();
    chk("t5_busy", 32'(bus.Busy), 0);
    for (int i = 0; i < 16; i++) rd_chk("t5_word", 1, 4'(i), i < 5 ? 16'h0000 : 16'hA000 + 16'(i));
    // random traffic with occasional clear and reset
    for (int c = 0; c < 1500; c++) begin
      quiet();
      rst = ($urandom_range(0, 199) == 0);
      bus.Clear = ($urandom_range(0, 63) == 0);
      bus.WriteEna_1 = 1'($urandom); bus.WriteEna_2 = 1'($urandom);
      bus.ReadEna_1 = 1'($urandom); bus.ReadEna_2 = 1'($urandom);
      bus.Address_1 = 4'($urandom);
      bus.Address_2 = ($urandom_range(0, 2) == 0) ? bus.Address_1 : 4'($urandom);
      bus.DataIn_1 = 16'($urandom); bus.DataIn_2 = 16'($urandom);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
